// File: rtl/hack_cpu_sequencer_if.sv
// Bus bundle between the Hack sequencer and its fetch port, external ALU and data memory.
// The sequencer uses the master modport; the environment (memories, ALU) uses slave.
interface hack_cpu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 15
);
    logic              instr_req;
    logic [PC_W-1:0]   instr_addr;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;

    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zx;
    logic              alu_nx;
    logic              alu_zy;
    logic              alu_ny;
    logic              alu_f;
    logic              alu_no;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;

    logic [14:0]       mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    logic              halted;

    modport master (
        output instr_req, instr_addr,
        input  instr_valid, instr_data,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        input  alu_out, alu_zr, alu_ng,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output halted
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_valid, instr_data,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        output alu_out, alu_zr, alu_ng,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  halted
    );
endinterface

// File: rtl/hack_cpu_sequencer.sv
// Multicycle Hack CPU sequencer: FETCH -> DECODE -> (EXECUTE -> WRITEBACK) around an external ALU.
// Define HACK_SEQ_HALT_EN to stop in a HALT state on an unconditional jump to itself.
module hack_cpu_sequencer #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hack_cpu_sequencer_if.master bus
);

`ifdef HACK_SEQ_HALT_EN
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
`else
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] d_reg;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] r_reg;
    logic              zr_q;
    logic              ng_q;
    logic              run_q;
    logic              instr_req;
    logic              c_active;
    logic              jump;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jump_target;
    logic [5:0]        alu_ctrl;

    // run_q keeps instr_req low until the first clock edge after reset release.
    assign instr_req   = run_q && (state == FETCH);
    assign c_active    = ir[15] && ((state == DECODE) || (state == EXECUTE) || (state == WRITEBACK));
    assign alu_ctrl    = c_active ? ir[11:6] : 6'b000000;
    assign pc_inc      = pc + PC_W'(1);
    assign jump_target = a_reg[PC_W-1:0];
    assign jump        = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~ng_q & ~zr_q);

    assign bus.instr_req  = instr_req;
    assign bus.instr_addr = pc;
    assign bus.alu_x      = c_active ? d_reg : '0;
    assign bus.alu_y      = c_active ? (ir[12] ? bus.mem_rdata : a_reg) : '0;
    assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = alu_ctrl;
    assign bus.mem_addr   = a_reg[14:0];
    assign bus.mem_wdata  = r_reg;
    assign bus.mem_we     = (state == WRITEBACK) && ir[3];

`ifdef HACK_SEQ_HALT_EN
    logic halt_hit;
    assign halt_hit   = (ir[2:0] == 3'b111) && (jump_target == pc);
    assign bus.halted = (state == HALT);
`else
    assign bus.halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (instr_req && bus.instr_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = ir[15] ? EXECUTE : FETCH;
            end
            EXECUTE: begin
                state_next = WRITEBACK;
            end
            WRITEBACK: begin
`ifdef HACK_SEQ_HALT_EN
                state_next = halt_hit ? HALT : FETCH;
`else
                state_next = FETCH;
`endif
            end
`ifdef HACK_SEQ_HALT_EN
            HALT: begin
                state_next = HALT;
            end
`endif
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Writeback reads a_reg before its own update, so mem_addr and the jump target use old A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            a_reg <= '0;
            d_reg <= '0;
            ir    <= '0;
            r_reg <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                FETCH: begin
                    if (instr_req && bus.instr_valid) begin
                        ir <= bus.instr_data;
                    end
                end
                DECODE: begin
                    if (!ir[15]) begin
                        a_reg <= ir;
                        pc    <= pc_inc;
                    end
                end
                EXECUTE: begin
                    r_reg <= bus.alu_out;
                    zr_q  <= bus.alu_zr;
                    ng_q  <= bus.alu_ng;
                end
                WRITEBACK: begin
                    if (ir[4]) begin
                        d_reg <= r_reg;
                    end
                    if (ir[5]) begin
                        a_reg <= r_reg;
                    end
                    pc <= jump ? jump_target : pc_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Directed bench for hack_cpu_sequencer with a Hack ALU model, data memory and a write scoreboard.
// Build with HACK_SEQ_HALT_EN defined to exercise the HALT state.
module tb_hack_cpu_sequencer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          errors   = 0;
    int          checks   = 0;
    int          wr_count = 0;
    logic [30:0] exp_wr[$];
    logic [15:0] dmem [0:255];
    logic [5:0]  ctrl_bits;

    hack_cpu_sequencer_if #(.DATA_W(16), .PC_W(15)) bus ();

    hack_cpu_sequencer #(
        .DATA_W   (16),
        .PC_W     (15),
        .RESET_PC (15'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign ctrl_bits = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};

    // Reference Hack ALU: returns {zr, ng, out}.
    function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] o;
        xx = c[5] ? 16'h0000 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0000 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? (xx + yy) : (xx & yy);
        o  = c[0] ? ~o : o;
        return {(o == 16'h0000), o[15], o};
    endfunction

    always_comb begin
        {bus.alu_zr, bus.alu_ng, bus.alu_out} = hack_alu(bus.alu_x, bus.alu_y, ctrl_bits);
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
        bus.mem_rdata <= dmem[bus.mem_addr[7:0]];
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_write(input logic [14:0] addr, input logic [15:0] data);
        exp_wr.push_back({addr, data});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;
        #1;
        check_output("rst_req", 32'(bus.instr_req), 32'd0);
        check_output("rst_we", 32'(bus.mem_we), 32'd0);
        check_output("rst_halted", 32'(bus.halted), 32'd0);
        check_output("rst_ctrl", 32'(ctrl_bits), 32'd0);
        repeat (2) @(negedge clk);
        check_output("rst_addr", 32'(bus.instr_addr), 32'd0);
        check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("req_before_edge", 32'(bus.instr_req), 32'd0);
        @(negedge clk);
        check_output("req_after_release", 32'(bus.instr_req), 32'd1);
        check_output("addr_after_release", 32'(bus.instr_addr), 32'd0);
        check_output("we_after_release", 32'(bus.mem_we), 32'd0);
    endtask

    // Wait for a fetch at exp_pc, hand over one instruction, then follow it to the next fetch.
    task automatic apply_stimulus(input logic [15:0] word, input logic [14:0] exp_pc,
                                  input int exp_lat, input logic chk_ctrl,
                                  input logic [5:0] exp_ctrl, input logic [15:0] exp_x,
                                  input logic [15:0] exp_y);
        int          lat;
        logic        done;
        logic [30:0] front;
        for (int n = 0; n < 20 && !bus.instr_req; n++) @(negedge clk);
        check_output("fetch_req", 32'(bus.instr_req), 32'd1);
        check_output("fetch_addr", 32'(bus.instr_addr), 32'(exp_pc));
        check_output("fetch_ctrl_zero", 32'(ctrl_bits), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instr_data  = word;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        lat  = 0;
        done = 1'b0;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            if (k == 1 && chk_ctrl) begin
                check_output("decode_ctrl", 32'(ctrl_bits), 32'(exp_ctrl));
                check_output("decode_x", 32'(bus.alu_x), 32'(exp_x));
                check_output("decode_y", 32'(bus.alu_y), 32'(exp_y));
            end
            if (bus.mem_we) begin
                check_output("write_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    front = exp_wr.pop_front();
                    check_output("write_addr", 32'(bus.mem_addr), 32'(front[30:16]));
                    check_output("write_data", 32'(bus.mem_wdata), 32'(front[15:0]));
                end
            end
            if (bus.instr_req || bus.halted) begin
                lat  = k;
                done = 1'b1;
            end
        end
        check_output("latency", 32'(lat), 32'(exp_lat));
        check_output("write_drain", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        int wr_before;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;

        do_reset();

        apply_stimulus(16'h0005, 15'h0000, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        check_output("a_after_at5", 32'(bus.mem_addr), 32'h5);
        apply_stimulus(16'hEC10, 15'h0001, 4, 1'b1, 6'b110000, 16'h0000, 16'h0005);
        push_write(15'h0005, 16'h0006);
        apply_stimulus(16'hE7C8, 15'h0002, 4, 1'b1, 6'b011111, 16'h0005, 16'h0005);
        apply_stimulus(16'hFC10, 15'h0003, 4, 1'b1, 6'b110000, 16'h0005, 16'h0006);
        apply_stimulus(16'h0020, 15'h0004, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        push_write(15'h0020, 16'h0006);
        apply_stimulus(16'hE308, 15'h0005, 4, 1'b1, 6'b001100, 16'h0006, 16'h0020);

        apply_stimulus(16'h7000, 15'h0006, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        apply_stimulus(16'hEC50, 15'h0007, 4, 1'b1, 6'b110001, 16'h0006, 16'h7000);
        apply_stimulus(16'h0010, 15'h0008, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        push_write(15'h0010, 16'h9000);
        apply_stimulus(16'hE7C8, 15'h0009, 4, 1'b1, 6'b011111, 16'h8FFF, 16'h0010);

        apply_stimulus(16'hEA90, 15'h000A, 4, 1'b1, 6'b101010, 16'h8FFF, 16'h0010);
        apply_stimulus(16'h0100, 15'h000B, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        apply_stimulus(16'hE302, 15'h000C, 4, 1'b1, 6'b001100, 16'h0000, 16'h0100);
        apply_stimulus(16'hE301, 15'h0100, 4, 1'b1, 6'b001100, 16'h0000, 16'h0100);
        apply_stimulus(16'hE7E7, 15'h0101, 4, 1'b1, 6'b011111, 16'h0000, 16'h0100);
        check_output("a_after_d1_jump", 32'(bus.mem_addr), 32'h1);
        apply_stimulus(16'hEE90, 15'h0100, 4, 1'b1, 6'b111010, 16'h0000, 16'h0001);
        apply_stimulus(16'h0200, 15'h0101, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        apply_stimulus(16'hE304, 15'h0102, 4, 1'b1, 6'b001100, 16'hFFFF, 16'h0200);

        apply_stimulus(16'h7FFF, 15'h0200, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        apply_stimulus(16'hEA87, 15'h0201, 4, 1'b1, 6'b101010, 16'hFFFF, 16'h7FFF);
        apply_stimulus(16'h0000, 15'h7FFF, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        apply_stimulus(16'hEA87, 15'h0000, 4, 1'b1, 6'b101010, 16'hFFFF, 16'h0000);
`ifdef HACK_SEQ_HALT_EN
        for (int n = 0; n < 5; n++) begin
            check_output("halted_set", 32'(bus.halted), 32'd1);
            check_output("halted_req_low", 32'(bus.instr_req), 32'd0);
            @(negedge clk);
        end
`else
        check_output("no_halt", 32'(bus.halted), 32'd0);
        check_output("self_loop_req", 32'(bus.instr_req), 32'd1);
        check_output("self_loop_addr", 32'(bus.instr_addr), 32'd0);
`endif

        do_reset();
        check_output("reset_clears_halt", 32'(bus.halted), 32'd0);
        apply_stimulus(16'h0007, 15'h0000, 2, 1'b0, 6'b0, 16'h0, 16'h0);
        apply_stimulus(16'hEC10, 15'h0001, 4, 1'b1, 6'b110000, 16'h0000, 16'h0007);
        apply_stimulus(16'h0000, 15'h0002, 2, 1'b0, 6'b0, 16'h0, 16'h0);

        for (int n = 0; n < 20 && !bus.instr_req; n++) @(negedge clk);
        check_output("abort_fetch_addr", 32'(bus.instr_addr), 32'h3);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 16'hE308;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_output("abort_we_pending", 32'(bus.mem_we), 32'd1);
        check_output("abort_wdata", 32'(bus.mem_wdata), 32'h7);
        wr_before = wr_count;
        rst_n = 1'b0;
        #1;
        check_output("abort_we_dropped", 32'(bus.mem_we), 32'd0);
        check_output("abort_req_low", 32'(bus.instr_req), 32'd0);
        repeat (2) @(negedge clk);
        check_output("abort_no_write", 32'(wr_count), 32'(wr_before));
        rst_n = 1'b1;
        @(negedge clk);
        check_output("abort_refetch_req", 32'(bus.instr_req), 32'd1);
        check_output("abort_refetch_addr", 32'(bus.instr_addr), 32'd0);

        $display("[TB] directed sequence complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
